alarm_time_store: RTL and testbench

Downstream stage of the alarm-setting state machine. It consumes that machine's one-cycle `hours`/`mins` increment strobes and holds the alarm time as BCD registers. It compares the stored time against the running time-of-day and sequences the ring output through IDLE, RINGING and SNOOZE, with second-based timeouts. The outputs feed the display mux (alarm time) and the buzzer driver (`ring`).

---
 rtl/alarm_time_store.sv | 144 ++++++++++++++
 tb/tb_alarm_time_store.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_time_store.sv
// rtl/alarm_time_store.sv - BCD alarm time registers, match detect and ring/snooze sequencer
module alarm_time_store #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hours,
  input  logic       mins,
  input  logic       alarm_en,
  input  logic [7:0] tod_hours,
  input  logic [7:0] tod_mins,
  input  logic       sec_tick,
  input  logic       stop,
  input  logic       snooze,
  output logic [7:0] alarm_hours,
  output logic [7:0] alarm_mins,
  output logic       ring,
  output logic       snoozing
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_e;

  // Last counter value before the timeout fires; the counter starts at 0 on entry.
  localparam logic [15:0] RING_LAST   = 16'(RING_SECS - 1);
  localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SECS - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  alarm_hours_q, alarm_hours_d;
  logic [7:0]  alarm_mins_q, alarm_mins_d;
  logic        match_q;
  logic        ring_q, snoozing_q;
  logic        match;
  logic        trigger;

  function automatic logic [7:0] inc_bcd_mins(input logic [7:0] v);
    if (v == 8'h59)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_bcd_hours(input logic [7:0] v);
    if (v == 8'h23)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Alarm time edits: each strobe bumps its own field, no carry between fields.
  always_comb begin
    alarm_hours_d = alarm_hours_q;
    alarm_mins_d  = alarm_mins_q;
    if (hours) alarm_hours_d = inc_bcd_hours(alarm_hours_q);
    if (mins)  alarm_mins_d  = inc_bcd_mins(alarm_mins_q);
  end

  // Fire once on the rising edge of a match, so a held matching minute rings only once.
  always_comb begin
    match   = alarm_en && (tod_hours == alarm_hours_q) && (tod_mins == alarm_mins_q);
    trigger = match && !match_q;
  end

  // Ring sequencer next state; the second counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (trigger) state_d = RINGING;
      end
      RINGING: begin
        if (!alarm_en || stop) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (snooze) begin
          state_d = SNOOZE;
          cnt_d   = 16'd0;
        end else if (sec_tick) begin
          if (cnt_q == RING_LAST) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      SNOOZE: begin
        if (!alarm_en || stop) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (sec_tick) begin
          if (cnt_q == SNOOZE_LAST) begin
            state_d = RINGING;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // State, counter, alarm time and registered outputs; outputs decode the next state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= 16'd0;
      alarm_hours_q <= 8'h00;
      alarm_mins_q  <= 8'h00;
      match_q       <= 1'b0;
      ring_q        <= 1'b0;
      snoozing_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alarm_hours_q <= alarm_hours_d;
      alarm_mins_q  <= alarm_mins_d;
      match_q       <= match;
      ring_q        <= (state_d == RINGING);
      snoozing_q    <= (state_d == SNOOZE);
    end
  end

  assign alarm_hours = alarm_hours_q;
  assign alarm_mins  = alarm_mins_q;
  assign ring        = ring_q;
  assign snoozing    = snoozing_q;

endmodule

// File: tb/tb_alarm_time_store.sv
// tb/tb_alarm_time_store.sv - self-checking bench for alarm_time_store
module tb_alarm_time_store;

  localparam int RING_N   = 3;
  localparam int SNOOZE_N = 2;

  logic       clk;
  logic       reset_n;
  logic       hours, mins, alarm_en, sec_tick, stop, snooze;
  logic [7:0] tod_hours, tod_mins;
  logic [7:0] alarm_hours, alarm_mins;
  logic       ring, snoozing;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: alarm as plain integers, ring behaviour as a mode plus ticks seen.
  int m_ah, m_am;
  int m_mode;       // 0 idle, 1 ringing, 2 snoozing
  int m_ticks;
  bit m_prev_match;

  alarm_time_store #(.RING_SECS(RING_N), .SNOOZE_SECS(SNOOZE_N)) dut (
    .clk(clk), .reset_n(reset_n), .hours(hours), .mins(mins), .alarm_en(alarm_en),
    .tod_hours(tod_hours), .tod_mins(tod_mins), .sec_tick(sec_tick), .stop(stop),
    .snooze(snooze), .alarm_hours(alarm_hours), .alarm_mins(alarm_mins),
    .ring(ring), .snoozing(snoozing)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [17:0] exp_vec();
    return {to_bcd(m_ah), to_bcd(m_am), (m_mode == 1), (m_mode == 2)};
  endfunction

  function automatic logic [17:0] got_vec();
    return {alarm_hours, alarm_mins, ring, snoozing};
  endfunction

  task automatic model_reset();
    m_ah = 0; m_am = 0; m_mode = 0; m_ticks = 0; m_prev_match = 1'b0;
  endtask

  // Apply one clock of the behavioural rules using the inputs currently driven.
  task automatic model_clock();
    bit cur_match;
    cur_match = alarm_en && (tod_hours == to_bcd(m_ah)) && (tod_mins == to_bcd(m_am));
    case (m_mode)
      0: if (cur_match && !m_prev_match) begin m_mode = 1; m_ticks = 0; end
      1: begin
        if (!alarm_en || stop) m_mode = 0;
        else if (snooze) begin m_mode = 2; m_ticks = 0; end
        else if (sec_tick) begin
          m_ticks++;
          if (m_ticks == RING_N) m_mode = 0;
        end
      end
      default: begin
        if (!alarm_en || stop) m_mode = 0;
        else if (sec_tick) begin
          m_ticks++;
          if (m_ticks == SNOOZE_N) begin m_mode = 1; m_ticks = 0; end
        end
      end
    endcase
    m_prev_match = cur_match;
    if (hours) m_ah = (m_ah + 1) % 24;
    if (mins)  m_am = (m_am + 1) % 60;
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hours = 0; mins = 0; sec_tick = 0; stop = 0; snooze = 0;
  endtask

  task automatic strobe(input bit h, input bit m);
    hours = h; mins = m;
    step();
    hours = 0; mins = 0;
  endtask

  task automatic set_alarm(input int h, input int m);
    for (int i = 0; i < 24 && m_ah != h; i++) strobe(1, 0);
    for (int i = 0; i < 60 && m_am != m; i++) strobe(0, 1);
  endtask

  task automatic test_reset();
    reset_n = 0; idle_inputs(); alarm_en = 0; tod_hours = 8'h00; tod_mins = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    if (got_vec() !== 18'd0) $display("FAIL reset: got %h want %h", got_vec(), 18'd0);
    else n_pass++;
    n_checks++;
    reset_n = 1;
    step();
    if (got_vec() !== exp_vec()) $display("FAIL reset_idle: got %h want %h", got_vec(), exp_vec());
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_mins_wrap();
    for (int i = 0; i < 60; i++) begin
      strobe(0, 1);
      if (got_vec() !== exp_vec()) $display("FAIL mins_wrap[%0d]: got %h want %h", i, got_vec(), exp_vec());
      else n_pass++;
      n_checks++;
    end
    if ({alarm_hours, alarm_mins} !== 16'h0000) $display("FAIL mins_wrap_end: got %h want 0000", {alarm_hours, alarm_mins});
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_hours_wrap();
    for (int i = 0; i < 24; i++) begin
      strobe(1, 0);
      if (i == 22 && alarm_hours !== 8'h23) $display("FAIL hours_23: got %h want 23", alarm_hours);
      if (got_vec() !== exp_vec()) $display("FAIL hours_wrap[%0d]: got %h want %h", i, got_vec(), exp_vec());
      else n_pass++;
      n_checks++;
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 23; i++) strobe(1, 1);
    for (int i = 0; i < 36; i++) strobe(0, 1);
    if ({alarm_hours, alarm_mins} !== 16'h2359) $display("FAIL simul_pre: got %h want 2359", {alarm_hours, alarm_mins});
    else n_pass++;
    n_checks++;
    strobe(1, 1);
    if ({alarm_hours, alarm_mins} !== 16'h0000) $display("FAIL simul_wrap: got %h want 0000", {alarm_hours, alarm_mins});
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_basic_ring();
    set_alarm(7, 30);
    alarm_en = 1; tod_hours = 8'h07; tod_mins = 8'h29;
    step();
    if (ring !== 1'b0) $display("FAIL ring_early: got %b want 0", ring);
    else n_pass++;
    n_checks++;
    tod_mins = 8'h30;
    step();
    if (ring !== 1'b1 || got_vec() !== exp_vec()) $display("FAIL ring_start: got %h want %h", got_vec(), exp_vec());
    else n_pass++;
    n_checks++;
    for (int i = 0; i < RING_N; i++) begin
      sec_tick = 1; step(); sec_tick = 0;
      if (ring !== (i < RING_N - 1) || got_vec() !== exp_vec())
        $display("FAIL ring_timeout[%0d]: got %h want %h", i, got_vec(), exp_vec());
      else n_pass++;
      n_checks++;
    end
    repeat (4) step();
    if (ring !== 1'b0) $display("FAIL no_retrigger: got %b want 0", ring);
    else n_pass++;
    n_checks++;
  endtask

  task automatic retrigger();
    tod_mins = 8'h00; step();
    tod_mins = to_bcd(m_am); tod_hours = to_bcd(m_ah); step();
  endtask

  task automatic test_snooze();
    retrigger();
    snooze = 1; step(); snooze = 0;
    if ({ring, snoozing} !== 2'b01) $display("FAIL snooze_enter: got %b want 01", {ring, snoozing});
    else n_pass++;
    n_checks++;
    for (int i = 0; i < SNOOZE_N; i++) begin
      sec_tick = 1; step(); sec_tick = 0;
      if (got_vec() !== exp_vec()) $display("FAIL snooze_tick[%0d]: got %h want %h", i, got_vec(), exp_vec());
      else n_pass++;
      n_checks++;
    end
    if ({ring, snoozing} !== 2'b10) $display("FAIL snooze_rering: got %b want 10", {ring, snoozing});
    else n_pass++;
    n_checks++;
    stop = 1; step(); stop = 0;
    if ({ring, snoozing} !== 2'b00) $display("FAIL snooze_stop: got %b want 00", {ring, snoozing});
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_priority();
    retrigger();
    stop = 1; snooze = 1; step(); stop = 0; snooze = 0;
    if ({ring, snoozing} !== 2'b00) $display("FAIL prio_stop_snooze: got %b want 00", {ring, snoozing});
    else n_pass++;
    n_checks++;
    retrigger();
    snooze = 1; step(); snooze = 0;
    alarm_en = 0; step(); alarm_en = 1;
    if ({ring, snoozing} !== 2'b00) $display("FAIL prio_en_drop: got %b want 00", {ring, snoozing});
    else n_pass++;
    n_checks++;
    retrigger();
    strobe(0, 1);
    if (ring !== 1'b1 || alarm_mins !== 8'h31 || got_vec() !== exp_vec())
      $display("FAIL prio_strobe_ring: got %h want %h", got_vec(), exp_vec());
    else n_pass++;
    n_checks++;
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_async_reset();
    tod_hours = to_bcd(m_ah); tod_mins = to_bcd(m_am); step();
    if (ring !== 1'b1) $display("FAIL arst_pre: got %b want 1", ring);
    else n_pass++;
    n_checks++;
    #2 reset_n = 0;
    #1;
    if (got_vec() !== 18'd0) $display("FAIL arst_clear: got %h want %h", got_vec(), 18'd0);
    else n_pass++;
    n_checks++;
    model_reset();
    @(posedge clk); #1;
    tod_hours = 8'h00; tod_mins = 8'h00; alarm_en = 1;
    reset_n = 1;
    step();
    if (ring !== 1'b1 || got_vec() !== exp_vec()) $display("FAIL arst_release_trigger: got %h want %h", got_vec(), exp_vec());
    else n_pass++;
    n_checks++;
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      hours    = ($urandom_range(0, 99) < 4);
      mins     = ($urandom_range(0, 99) < 4);
      sec_tick = ($urandom_range(0, 99) < 35);
      stop     = ($urandom_range(0, 99) < 3);
      snooze   = ($urandom_range(0, 99) < 6);
      alarm_en = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 99) < 10) begin
        if ($urandom_range(0, 1) == 1) begin
          tod_hours = to_bcd(m_ah); tod_mins = to_bcd(m_am);
        end else begin
          tod_hours = to_bcd($urandom_range(0, 23)); tod_mins = to_bcd($urandom_range(0, 59));
        end
      end
      step();
      if (got_vec() !== exp_vec() || (ring && snoozing))
        $display("FAIL random[%0d]: got %h want %h", i, got_vec(), exp_vec());
      else n_pass++;
      n_checks++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_mins_wrap();
    test_hours_wrap();
    test_simultaneous();
    test_basic_ring();
    test_snooze();
    test_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
